// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_pkg
//  Description : Shared definitions for the RAM stream reader: controller
//                state encoding, depth derivation and the length clamp.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package ram_pkg;

    typedef logic [1:0] state_t;

    localparam state_t C_ST_IDLE  = 2'd0;
    localparam state_t C_ST_READ  = 2'd1;
    localparam state_t C_ST_FLUSH = 2'd2;
    localparam state_t C_ST_DONE  = 2'd3;

    // Number of words addressable with an address of width aw.
    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

    // Requests longer than the RAM are limited to one full pass.
    function automatic int clamp_length(input int len, input int aw);
        int d;
        d = depth_of(aw);
        return (len > d) ? d : len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_stream_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : ram_stream_reader_if
//  Description : Bundles the command, RAM-side and stream-side signals of the
//                RAM stream reader.
//  Ports       : master modport - reader view (drives RAM address/we, status
//                and the output stream); slave modport - environment view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ram_stream_reader_if #(
    parameter int AWIDTH = 3,
    parameter int DWIDTH = 32
);
    logic              start;
    logic [AWIDTH-1:0] base_addr;
    logic [AWIDTH:0]   length;
    logic              busy;
    logic              done;
    logic [AWIDTH-1:0] mem_addr;
    logic              mem_we;
    logic [DWIDTH-1:0] mem_dout;
    logic              m_valid;
    logic              m_ready;
    logic [DWIDTH-1:0] m_data;
    logic              m_last;

    modport master (
        input  start, base_addr, length, mem_dout, m_ready,
        output busy, done, mem_addr, mem_we, m_valid, m_data, m_last
    );

    modport slave (
        output start, base_addr, length, mem_dout, m_ready,
        input  busy, done, mem_addr, mem_we, m_valid, m_data, m_last
    );
endinterface
`default_nettype wire

// File: rtl/ram_skid_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ram_skid_fifo
//  Description : Two-entry FIFO with a registered head entry. Push and pop may
//                occur in the same cycle. The caller guarantees no push into a
//                full FIFO without a simultaneous pop.
//  Ports       : clock, reset_n (sync, active-low), push/push_data,
//                pop, head (registered head entry), valid, occupancy (0..2)
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_skid_fifo #(
    parameter int WIDTH = 33
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic [1:0]       occupancy
);
    localparam logic [1:0] C_ONE = 2'd1;

    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic [1:0]       r_count;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (r_count == 2'd0) r_head <= push_data;
                    else                 r_tail <= push_data;
                    r_count <= r_count + C_ONE;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - C_ONE;
                end
                2'b11: begin
                    // Occupancy is unchanged; the new word lands behind
                    // whatever remains after the pop.
                    if (r_count == 2'd2) begin
                        r_head <= r_tail;
                        r_tail <= push_data;
                    end else begin
                        r_head <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head      = r_head;
    assign valid     = (r_count != 2'd0);
    assign occupancy = r_count;

endmodule
`default_nettype wire

// File: rtl/ram_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : ram_stream_reader
//  Description : Walks a wrapping address range of a synchronous-read RAM,
//                absorbs its one-cycle read latency and streams the words on
//                a valid/ready interface with full backpressure.
//  Ports       : clock, reset_n (sync, active-low),
//                bus (master modport): start/base_addr/length command,
//                busy/done status, mem_addr/mem_we/mem_dout RAM port,
//                m_valid/m_ready/m_data/m_last output stream
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_stream_reader
    import ram_pkg::*;
#(
    parameter int AWIDTH = 3,
    parameter int DWIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset_n,
    ram_stream_reader_if.master  bus
);
    localparam logic [AWIDTH-1:0] C_ADDR_ONE = 1;
    localparam logic [AWIDTH:0]   C_REM_ONE  = 1;

    state_t            r_state;
    state_t            w_state_next;
    logic [AWIDTH-1:0] r_addr;
    logic [AWIDTH:0]   r_rem;
    logic [AWIDTH:0]   w_len_clamped;
    logic              r_inflight;
    logic              r_inflight_last;
    logic              w_issue;
    logic              w_final_issue;
    logic              w_pop;
    logic [1:0]        w_occ;
    logic [1:0]        w_pending;
    logic [DWIDTH:0]   w_head;
    logic              w_fifo_valid;

    assign w_len_clamped = (AWIDTH+1)'(clamp_length(int'(bus.length), AWIDTH));

    assign w_pop     = w_fifo_valid & bus.m_ready;
    // Words already buffered plus the one arriving from the RAM next cycle.
    assign w_pending = w_occ + {1'b0, r_inflight};
    assign w_issue   = (r_state == C_ST_READ) && (r_rem != '0) &&
                       ((w_pending <= 2'd1) || ((w_pending == 2'd2) && w_pop));
    assign w_final_issue = w_issue && (r_rem == C_REM_ONE);

    // ---------------- state register ----------------
    always_ff @(posedge clock) begin
        if (!reset_n) r_state <= C_ST_IDLE;
        else          r_state <= w_state_next;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            C_ST_IDLE: begin
                if (bus.start)
                    w_state_next = (w_len_clamped == '0) ? C_ST_DONE : C_ST_READ;
            end
            C_ST_READ: begin
                if (w_final_issue) w_state_next = C_ST_FLUSH;
            end
            C_ST_FLUSH: begin
                if (w_pop && w_head[DWIDTH]) w_state_next = C_ST_DONE;
            end
            C_ST_DONE: w_state_next = C_ST_IDLE;
            default:   w_state_next = C_ST_IDLE;
        endcase
    end

    // ---------------- status outputs ----------------
    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (r_state)
            C_ST_READ, C_ST_FLUSH: bus.busy = 1'b1;
            C_ST_DONE:             bus.done = 1'b1;
            default: ;
        endcase
    end

    // ---------------- address / remaining counters ----------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_addr <= '0;
            r_rem  <= '0;
        end else if ((r_state == C_ST_IDLE) && bus.start) begin
            r_addr <= bus.base_addr;
            r_rem  <= w_len_clamped;
        end else if (w_issue) begin
            r_addr <= r_addr + C_ADDR_ONE;
            r_rem  <= r_rem - C_REM_ONE;
        end
    end

    // RAM data for an issue appears one cycle later; remember that it is due
    // and whether it is the final word of the transfer.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= w_final_issue;
        end
    end

    ram_skid_fifo #(
        .WIDTH (DWIDTH + 1)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (r_inflight),
        .push_data ({r_inflight_last, bus.mem_dout}),
        .pop       (w_pop),
        .head      (w_head),
        .valid     (w_fifo_valid),
        .occupancy (w_occ)
    );

    assign bus.mem_addr = r_addr;
    assign bus.mem_we   = 1'b0;
    assign bus.m_valid  = w_fifo_valid;
    assign bus.m_data   = w_head[DWIDTH-1:0];
    assign bus.m_last   = w_head[DWIDTH];

endmodule
`default_nettype wire
